// File: rtl/inst_fetch_pkg.sv
// Shared types and defaults for the instruction-fetch block.
package inst_fetch_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int CNT_W      = 16;
  localparam logic [31:0] NOP_WORD = 32'h0;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2,
    ST_DONE  = 2'd3
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_t;

  // Delivered-instruction counter step; sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Memory-side and decode-side signals of the fetch unit.
interface inst_fetch_if import inst_fetch_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              instr_valid;

  modport master (
    output mem_addr, instr, instr_pc, instr_valid,
    input  mem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  mem_addr, instr, instr_pc, instr_valid,
    output mem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Program counter register with hold / increment / load selection.
module inst_fetch_pc_reg import inst_fetch_pkg::*; #(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  pc_sel_t           sel,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  // PC update: advance, jump to load_pc, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      case (sel)
        PC_INC:  pc <= pc + ADDR_W'(1);
        PC_LOAD: pc <= load_pc;
        default: pc <= pc;
      endcase
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch initiator: sequences PC, captures memory words for decode.
//
// state    | meaning
// ST_WAIT  | memory init window after reset, no fetching
// ST_FETCH | fetching one word per unstalled cycle
// ST_HALT  | stopped until reset, pc frozen
// ST_DONE  | past END_ADDR; holds last word until decode takes it
module inst_fetch import inst_fetch_pkg::*; #(
  parameter int                ADDR_W    = ADDR_W_DEF,
  parameter int                DATA_W    = DATA_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [ADDR_W-1:0] END_ADDR  = ADDR_W'(10),
  parameter int                INIT_WAIT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  inst_fetch_if.master      bus,
  input  logic              halt_req,
  output logic [ADDR_W-1:0] pc_out,
  output logic [CNT_W-1:0]  fetch_count,
  output logic              done
);

  localparam int WAIT_W = (INIT_WAIT > 1) ? $clog2(INIT_WAIT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(INIT_WAIT - 1);
  localparam fetch_state_t RESET_ST = (INIT_WAIT == 0) ? ST_FETCH : ST_WAIT;

  fetch_state_t      state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [ADDR_W-1:0] pc;
  pc_sel_t           pc_sel;
  logic              capture;
  logic              clr_valid;
  logic              wait_inc;

  inst_fetch_pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .sel     (pc_sel),
    .load_pc (bus.redirect_pc),
    .pc      (pc)
  );

  assign bus.mem_addr = pc;
  assign pc_out       = pc;
  assign done         = (state == ST_DONE);

  // Next state and datapath controls; halt beats redirect beats stall.
  always_comb begin
    state_nxt = state;
    pc_sel    = PC_HOLD;
    capture   = 1'b0;
    clr_valid = 1'b0;
    wait_inc  = 1'b0;
    case (state)
      ST_WAIT: begin
        wait_inc = 1'b1;
        if (wait_cnt == WAIT_LAST) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (halt_req) begin
          state_nxt = ST_HALT;
          clr_valid = 1'b1;
        end else if (bus.redirect) begin
          clr_valid = 1'b1;
          if (bus.redirect_pc > END_ADDR) state_nxt = ST_DONE;
          else                            pc_sel    = PC_LOAD;
        end else if (!bus.stall) begin
          capture = 1'b1;
          if (pc == END_ADDR) state_nxt = ST_DONE;
          else                pc_sel    = PC_INC;
        end
      end
      ST_DONE: begin
        if (bus.redirect && (bus.redirect_pc <= END_ADDR)) begin
          state_nxt = ST_FETCH;
          pc_sel    = PC_LOAD;
          clr_valid = 1'b1;
        end else if (!bus.stall) begin
          clr_valid = 1'b1;
        end
      end
      ST_HALT: clr_valid = 1'b1;
      default: state_nxt = RESET_ST;
    endcase
  end

  // State, wait counter, fetch register and delivered count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= RESET_ST;
      wait_cnt        <= '0;
      bus.instr       <= DATA_W'(NOP_WORD);
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      fetch_count     <= '0;
    end else begin
      state <= state_nxt;
      if (wait_inc) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (capture) begin
        bus.instr       <= bus.mem_rdata;
        bus.instr_pc    <= pc;
        bus.instr_valid <= 1'b1;
        fetch_count     <= sat_inc(fetch_count);
      end else if (clr_valid) begin
        bus.instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int END = 10;
  localparam int IW  = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          halt_req = 1'b0;
  logic [AW-1:0] pc_out;
  logic [15:0]   fetch_count;
  logic          done;
  logic [DW-1:0] mem [16];

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int            m_wait_left;
  bit            m_halted, m_done, m_valid;
  int            m_pc, m_ipc, m_cnt;
  logic [DW-1:0] m_instr;

  inst_fetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign bus.mem_rdata = (bus.mem_addr < AW'(16)) ? mem[bus.mem_addr[3:0]] : '0;

  inst_fetch #(
    .ADDR_W(AW), .DATA_W(DW), .RESET_PC('0), .END_ADDR(AW'(END)), .INIT_WAIT(IW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.master),
    .halt_req    (halt_req),
    .pc_out      (pc_out),
    .fetch_count (fetch_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_wait_left = IW;
    m_halted = 0; m_done = 0; m_valid = 0;
    m_pc = 0; m_ipc = 0; m_cnt = 0; m_instr = '0;
  endtask

  task automatic model_step(input bit h, input bit r, input int rpc, input bit s);
    if (m_wait_left > 0) begin
      m_wait_left--;
    end else if (m_halted) begin
      m_valid = 0;
    end else if (m_done) begin
      if (r && rpc <= END) begin m_pc = rpc; m_done = 0; m_valid = 0; end
      else if (!s) m_valid = 0;
    end else if (h) begin
      m_halted = 1; m_valid = 0;
    end else if (r) begin
      m_valid = 0;
      if (rpc > END) m_done = 1; else m_pc = rpc;
    end else if (!s) begin
      m_instr = mem[m_pc]; m_ipc = m_pc; m_valid = 1;
      m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
      if (m_pc == END) m_done = 1; else m_pc = m_pc + 1;
    end
  endtask

  task automatic drive_cycle(input bit h, input bit r, input int rpc, input bit s);
    halt_req = h; bus.redirect = r; bus.redirect_pc = AW'(rpc); bus.stall = s;
    @(posedge clk);
    model_step(h, r, rpc, s);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    halt_req = 0; bus.redirect = 0; bus.redirect_pc = '0; bus.stall = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    halt_req = 0; bus.redirect = 0; bus.redirect_pc = '0; bus.stall = 0;
    #2;
    vectors++; if (pc_out !== 16'd0) begin miscompares++; $display("FAIL reset_pc: got %0d expected 0", pc_out); end
    vectors++; if (bus.mem_addr !== 16'd0) begin miscompares++; $display("FAIL reset_mem_addr: got %0d expected 0", bus.mem_addr); end
    vectors++; if (bus.instr !== 32'd0) begin miscompares++; $display("FAIL reset_instr: got %0h expected 0", bus.instr); end
    vectors++; if (bus.instr_pc !== 16'd0) begin miscompares++; $display("FAIL reset_instr_pc: got %0d expected 0", bus.instr_pc); end
    vectors++; if (bus.instr_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b expected 0", bus.instr_valid); end
    vectors++; if (fetch_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", fetch_count); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %0b expected 0", done); end
  endtask

  task automatic test_straight_line();
    apply_reset();
    drive_cycle(0, 0, 0, 0);
    vectors++; if (bus.instr_valid !== 1'b0 || pc_out !== 16'd0) begin
      miscompares++; $display("FAIL wait_cycle: got valid=%0b pc=%0d expected valid=0 pc=0", bus.instr_valid, pc_out);
    end
    for (int k = 0; k <= END; k++) begin
      drive_cycle(0, 0, 0, 0);
      vectors++;
      if (bus.instr !== DW'(100 + k) || bus.instr_pc !== AW'(k) || bus.instr_valid !== 1'b1 || done !== (k == END)) begin
        miscompares++;
        $display("FAIL seq_word%0d: got instr=%0d pc=%0d valid=%0b done=%0b expected instr=%0d pc=%0d valid=1 done=%0b",
                 k, bus.instr, bus.instr_pc, bus.instr_valid, done, 100 + k, k, k == END);
      end
    end
    vectors++; if (fetch_count !== 16'd11) begin miscompares++; $display("FAIL seq_count: got %0d expected 11", fetch_count); end
    vectors++; if (pc_out !== AW'(END)) begin miscompares++; $display("FAIL end_pc: got %0d expected %0d", pc_out, END); end
    drive_cycle(0, 0, 0, 0);
    vectors++;
    if (bus.instr_valid !== 1'b0 || done !== 1'b1 || pc_out !== AW'(END) || bus.instr_pc !== AW'(END)) begin
      miscompares++;
      $display("FAIL done_consume: got valid=%0b done=%0b pc=%0d ipc=%0d expected valid=0 done=1 pc=10 ipc=10",
               bus.instr_valid, done, pc_out, bus.instr_pc);
    end
  endtask

  task automatic test_stall();
    apply_reset();
    idle_cycles(4);
    vectors++; if (pc_out !== 16'd3 || bus.instr !== 32'd102) begin
      miscompares++; $display("FAIL stall_setup: got pc=%0d instr=%0d expected pc=3 instr=102", pc_out, bus.instr);
    end
    for (int i = 0; i < 3; i++) begin
      drive_cycle(0, 0, 0, 1);
      vectors++;
      if (bus.instr !== 32'd102 || bus.instr_pc !== 16'd2 || pc_out !== 16'd3 || bus.instr_valid !== 1'b1 || fetch_count !== 16'd3) begin
        miscompares++;
        $display("FAIL stall_hold%0d: got instr=%0d ipc=%0d pc=%0d valid=%0b cnt=%0d expected 102/2/3/1/3",
                 i, bus.instr, bus.instr_pc, pc_out, bus.instr_valid, fetch_count);
      end
    end
    drive_cycle(0, 0, 0, 0);
    vectors++; if (bus.instr !== 32'd103 || bus.instr_pc !== 16'd3) begin
      miscompares++; $display("FAIL stall_resume: got instr=%0d ipc=%0d expected 103/3", bus.instr, bus.instr_pc);
    end
  endtask

  task automatic test_redirect();
    apply_reset();
    idle_cycles(5);
    drive_cycle(0, 1, 7, 1);
    vectors++; if (bus.instr_valid !== 1'b0 || pc_out !== 16'd7) begin
      miscompares++; $display("FAIL redir_squash: got valid=%0b pc=%0d expected valid=0 pc=7", bus.instr_valid, pc_out);
    end
    drive_cycle(0, 0, 0, 0);
    vectors++; if (bus.instr !== 32'd107 || bus.instr_pc !== 16'd7 || bus.instr_valid !== 1'b1) begin
      miscompares++; $display("FAIL redir_target: got instr=%0d ipc=%0d valid=%0b expected 107/7/1", bus.instr, bus.instr_pc, bus.instr_valid);
    end
    drive_cycle(0, 1, 12, 0);
    vectors++; if (done !== 1'b1 || bus.instr_valid !== 1'b0) begin
      miscompares++; $display("FAIL redir_past_end: got done=%0b valid=%0b expected done=1 valid=0", done, bus.instr_valid);
    end
    drive_cycle(0, 1, 2, 0);
    vectors++; if (done !== 1'b0 || pc_out !== 16'd2) begin
      miscompares++; $display("FAIL done_redirect: got done=%0b pc=%0d expected done=0 pc=2", done, pc_out);
    end
    drive_cycle(0, 0, 0, 0);
    vectors++; if (bus.instr !== 32'd102 || bus.instr_valid !== 1'b1) begin
      miscompares++; $display("FAIL done_refetch: got instr=%0d valid=%0b expected 102/1", bus.instr, bus.instr_valid);
    end
  endtask

  task automatic test_halt();
    apply_reset();
    idle_cycles(4);
    drive_cycle(1, 1, 7, 0);
    vectors++; if (pc_out !== 16'd3 || bus.instr_valid !== 1'b0 || done !== 1'b0) begin
      miscompares++; $display("FAIL halt_enter: got pc=%0d valid=%0b done=%0b expected 3/0/0", pc_out, bus.instr_valid, done);
    end
    for (int i = 0; i < 8; i++) begin
      drive_cycle($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 12), $urandom_range(0, 1));
      vectors++;
      if (pc_out !== 16'd3 || bus.instr_valid !== 1'b0 || done !== 1'b0 || fetch_count !== 16'd3) begin
        miscompares++;
        $display("FAIL halt_hold%0d: got pc=%0d valid=%0b done=%0b cnt=%0d expected 3/0/0/3", i, pc_out, bus.instr_valid, done, fetch_count);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    idle_cycles(7);
    vectors++; if (pc_out !== 16'd6 || bus.instr_valid !== 1'b1) begin
      miscompares++; $display("FAIL areset_setup: got pc=%0d valid=%0b expected 6/1", pc_out, bus.instr_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (pc_out !== 16'd0 || bus.instr !== 32'd0 || bus.instr_pc !== 16'd0 || bus.instr_valid !== 1'b0 || fetch_count !== 16'd0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL areset_clear: got pc=%0d instr=%0d ipc=%0d valid=%0b cnt=%0d done=%0b expected all zero",
               pc_out, bus.instr, bus.instr_pc, bus.instr_valid, fetch_count, done);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_cycle(0, 0, 0, 0);
    vectors++; if (bus.instr_valid !== 1'b0 || pc_out !== 16'd0) begin
      miscompares++; $display("FAIL areset_wait: got valid=%0b pc=%0d expected 0/0", bus.instr_valid, pc_out);
    end
    drive_cycle(0, 0, 0, 0);
    vectors++; if (bus.instr !== 32'd100 || bus.instr_pc !== 16'd0 || bus.instr_valid !== 1'b1) begin
      miscompares++; $display("FAIL areset_restart: got instr=%0d ipc=%0d valid=%0b expected 100/0/1", bus.instr, bus.instr_pc, bus.instr_valid);
    end
  endtask

  task automatic test_random();
    logic [AW+DW+AW+1+16+1-1:0] got, exp;
    int halted_for;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    apply_reset();
    halted_for = 0;
    for (int n = 0; n < 400; n++) begin
      if (m_halted) halted_for++;
      if (halted_for > 5) begin
        apply_reset();
        halted_for = 0;
      end
      drive_cycle($urandom_range(0, 79) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 12), $urandom_range(0, 3) == 0);
      got = {pc_out, bus.instr, bus.instr_pc, bus.instr_valid, fetch_count, done};
      exp = {AW'(m_pc), m_instr, AW'(m_ipc), m_valid, 16'(m_cnt), m_done};
      vectors++;
      if (got !== exp || bus.mem_addr !== pc_out) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got pc=%0d instr=%0h ipc=%0d valid=%0b cnt=%0d done=%0b addr=%0d expected pc=%0d instr=%0h ipc=%0d valid=%0b cnt=%0d done=%0b",
                 n, pc_out, bus.instr, bus.instr_pc, bus.instr_valid, fetch_count, done, bus.mem_addr,
                 m_pc, m_instr, m_ipc, m_valid, m_cnt, m_done);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = DW'(i + 100);
    test_reset();
    test_straight_line();
    test_stall();
    test_redirect();
    test_halt();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
